// File: rtl/riscv_dmem_read_data_pipe.sv
// Load-data return stage: rotates dmem response beats into place, assembles
// bus-word-crossing loads from two beats, extends and holds the result for writeback.
module riscv_dmem_read_data_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter bit SPLIT_ENABLE = 1'b1
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [$clog2(DATA_WIDTH/8)-1:0] req_offset,
  input  logic [1:0]                      req_size,
  input  logic                            req_unsigned,
  input  logic                            resp_valid,
  input  logic [DATA_WIDTH-1:0]           resp_data,
  input  logic                            resp_error,
  output logic                            rd_valid,
  input  logic                            rd_ready,
  output logic [DATA_WIDTH-1:0]           rd_data,
  output logic                            rd_error,
  output logic                            stray_resp
);

  localparam int B  = DATA_WIDTH / 8;
  localparam int OW = $clog2(B);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_FIRST  = 2'd1,
    WAIT_SECOND = 2'd2,
    HOLD        = 2'd3
  } state_t;

  function automatic int nbytes_of(input logic [1:0] size);
    int n;
    case (size)
      2'd0:    n = 32'sd1;
      2'd1:    n = 32'sd2;
      2'd2:    n = 32'sd4;
      default: n = 32'sd8;
    endcase
    return n;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] rotr_bytes(input logic [DATA_WIDTH-1:0] d,
                                                       input int off);
    logic [DATA_WIDTH-1:0] r;
    r = d;
    for (int j = 0; j < B; j++) begin
      r[8*j +: 8] = d[8*((j + off) % B) +: 8];
    end
    return r;
  endfunction

  // Beat 1 fills the low part of the result; beat 2 fills what wrapped past the bus word.
  function automatic logic [B-1:0] byte_mask(input int nb, input int off, input logic second);
    logic [B-1:0] m;
    m = {B{1'b0}};
    for (int j = 0; j < B; j++) begin
      if (second) begin
        m[j] = (j >= (B - off)) && (j < nb);
      end else begin
        m[j] = (j < nb) && (j < (B - off));
      end
    end
    return m;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(input logic [DATA_WIDTH-1:0] acc,
                                                        input logic [DATA_WIDTH-1:0] a,
                                                        input logic [B-1:0] m);
    logic [DATA_WIDTH-1:0] r;
    r = acc;
    for (int j = 0; j < B; j++) begin
      r[8*j +: 8] = m[j] ? a[8*j +: 8] : acc[8*j +: 8];
    end
    return r;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] extend(input logic [DATA_WIDTH-1:0] d,
                                                   input int nb, input logic uns);
    logic [DATA_WIDTH-1:0] r;
    logic                  sgn;
    r   = d;
    sgn = d[8*nb-1];
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (i >= 8*nb) begin
        r[i] = uns ? 1'b0 : sgn;
      end
    end
    return r;
  endfunction

  state_t                r_state;
  logic [OW-1:0]         r_offset;
  logic [1:0]            r_size;
  logic                  r_unsigned;
  logic                  r_split;
  logic [DATA_WIDTH-1:0] r_acc;
  logic                  r_err;
  logic                  r_rd_valid;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_error;
  logic                  r_stray;

  int                    w_req_nb;
  logic                  w_req_split;
  logic                  w_req_illegal;
  int                    w_nb;
  int                    w_off;
  logic [DATA_WIDTH-1:0] w_aligned;
  logic [B-1:0]          w_mask;
  logic [DATA_WIDTH-1:0] w_merged;
  logic                  w_err;
  logic [DATA_WIDTH-1:0] w_final;

  assign w_req_nb      = nbytes_of(req_size);
  assign w_req_split   = (int'(req_offset) + w_req_nb) > B;
  assign w_req_illegal = ((DATA_WIDTH == 32) && (req_size == 2'd3)) ||
                         (w_req_split && !SPLIT_ENABLE);

  assign w_nb      = nbytes_of(r_size);
  assign w_off     = int'(r_offset);
  assign w_aligned = rotr_bytes(resp_data, w_off);
  assign w_mask    = byte_mask(w_nb, w_off, r_state == WAIT_SECOND);
  assign w_merged  = merge_bytes(r_acc, w_aligned, w_mask);
  assign w_err     = r_err | resp_error;
  assign w_final   = w_err ? {DATA_WIDTH{1'b0}} : extend(w_merged, w_nb, r_unsigned);

  assign req_ready  = (r_state == IDLE);
  assign rd_valid   = r_rd_valid;
  assign rd_data    = r_rd_data;
  assign rd_error   = r_rd_error;
  assign stray_resp = r_stray;

  // Load FSM: request capture, beat assembly, result hold and stray-beat flagging.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_offset   <= {OW{1'b0}};
      r_size     <= 2'd0;
      r_unsigned <= 1'b0;
      r_split    <= 1'b0;
      r_acc      <= {DATA_WIDTH{1'b0}};
      r_err      <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= {DATA_WIDTH{1'b0}};
      r_rd_error <= 1'b0;
      r_stray    <= 1'b0;
    end else begin
      r_stray <= 1'b0;
      case (r_state)
        IDLE: begin
          r_stray <= resp_valid;
          if (req_valid) begin
            r_offset   <= req_offset;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_split    <= w_req_split;
            r_acc      <= {DATA_WIDTH{1'b0}};
            r_err      <= 1'b0;
            if (w_req_illegal) begin
              r_state    <= HOLD;
              r_rd_valid <= 1'b1;
              r_rd_data  <= {DATA_WIDTH{1'b0}};
              r_rd_error <= 1'b1;
            end else begin
              r_state <= WAIT_FIRST;
            end
          end
        end
        WAIT_FIRST: begin
          if (resp_valid) begin
            r_acc <= w_merged;
            r_err <= w_err;
            if (r_split) begin
              r_state <= WAIT_SECOND;
            end else begin
              r_state    <= HOLD;
              r_rd_valid <= 1'b1;
              r_rd_data  <= w_final;
              r_rd_error <= w_err;
            end
          end
        end
        WAIT_SECOND: begin
          if (resp_valid) begin
            r_acc      <= w_merged;
            r_err      <= w_err;
            r_state    <= HOLD;
            r_rd_valid <= 1'b1;
            r_rd_data  <= w_final;
            r_rd_error <= w_err;
          end
        end
        HOLD: begin
          r_stray <= resp_valid;
          if (rd_ready) begin
            r_state    <= IDLE;
            r_rd_valid <= 1'b0;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_rd_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/riscv_dmem_read_data_pipe.md
# riscv_dmem_read_data_pipe

Registered, parametrised load-data return stage for the RISC-V data-memory path, sitting between the dmem response bus and the writeback stage. It rotates each memory response into place and merges bytes under a per-beat enable mask. It assembles loads that cross a bus-word boundary from two consecutive response beats, then sign- or zero-extends the result. The result is held in an output register with a valid/ready handshake.

## Interface
- DATA_WIDTH, 32: bus and result width; 32 or 64 only. B = DATA_WIDTH/8 bytes; OW = log2(B).
- SPLIT_ENABLE, 1: 1 = boundary-crossing loads are assembled from two beats; 0 = they are reported as errors.
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  load request presented.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_offset  in  OW  byte offset of load address within the bus word.
- req_size  in  2  0 byte, 1 half, 2 word, 3 dword (64-bit only).
- req_unsigned  in  1  1 = zero-extend, 0 = sign-extend.
- resp_valid  in  1  memory response beat present; no back-pressure.
- resp_data  in  DATA_WIDTH  response data, little-endian.
- resp_error  in  1  response beat faulted.
- rd_valid  out  1  result available.
- rd_ready  in  1  consumer accepts result.
- rd_data  out  DATA_WIDTH  extended load result.
- rd_error  out  1  result is a fault; rd_data is 0.
- stray_resp  out  1  one-cycle pulse: resp_valid arrived while no beat was expected.

## Operation
- States: IDLE, WAIT_FIRST, WAIT_SECOND, HOLD. req_ready = (state == IDLE).
- Request capture: on accept, latch offset, size, unsigned. Compute nbytes = 1 << size and split = (offset + nbytes > B).
- Illegal request: size 3 with DATA_WIDTH=32, or split with SPLIT_ENABLE=0.
  - Go directly to HOLD with rd_error=1 and rd_data=0.
  - Consume no response beat.
- Legal request: go to WAIT_FIRST.
- Every beat: aligned = resp_data rotated right by offset*8 bits, so byte j of aligned = resp_data byte (offset+j) mod B.
- Beat 1 enables result bytes j < min(nbytes, B-offset). Beat 2 (split only) enables bytes B-offset <= j < nbytes.
- Merge: result bytes outside the enabled set keep their accumulated value. Accumulator clears to 0 on request accept.
- WAIT_FIRST + resp_valid:
  - split → WAIT_SECOND;
  - otherwise → HOLD.
- WAIT_SECOND + resp_valid → HOLD.
- Error: resp_error on any beat sets a sticky error. A split load still consumes its second beat (discarded) to keep response alignment.
  - On entry to HOLD with sticky error: rd_error=1, rd_data=0.
- Extension, applied at HOLD entry when no error:
  - bytes >= nbytes are zero;
  - if !unsigned and nbytes < B, bit 8*nbytes-1 is replicated into all higher bits.
- HOLD: rd_valid=1. rd_data and rd_error are stable until rd_valid && rd_ready, then → IDLE.
- resp_valid in IDLE or HOLD: beat is ignored, stray_resp pulses the next cycle, state is unchanged.

## Timing
- Reset (asynchronous, reset_n=0): state IDLE, rd_valid=0, rd_data=0, rd_error=0, stray_resp=0, accumulator 0, sticky error 0. req_ready=1 once reset is released.
- Reset mid-operation discards any partial assembly; no output is produced for that request.
- Final beat at cycle N → rd_valid=1 at N+1.
- Illegal request accepted at N → rd_valid at N+1.
- A response beat may arrive in the cycle after acceptance at the earliest; a beat coincident with acceptance counts as stray.
- Handshake at cycle N → rd_valid=0 and req_ready=1 at N+1.
- Best-case throughput: one unsplit load per 3 cycles.
- All outputs are registered except req_ready, which decodes state.

## Test plan
- 32-bit aligned load: word, offset 0, signed, resp 0x8765_4321 → rd_data 0x8765_4321, rd_error 0, rd_valid one cycle after the beat.
- 32-bit byte load: offset 3, signed, resp 0x80FF_FFFF → rd_data 0xFFFF_FF80; same request with unsigned → 0x0000_0080.
- 32-bit split load: word, offset 2, beats 0xAABB_CCDD then 0x1122_3344 → rd_data 0x3344_AABB.
  - Same request with SPLIT_ENABLE=0 → immediate rd_error=1, rd_data 0, no beat consumed.
- 64-bit split half: offset 7, signed, beat1 byte7=0x80, beat2 byte0=0xFF → rd_data 0xFFFF_FFFF_FFFF_FF80.
- Back-pressure, error and stray beat:
  - rd_ready low for 3 cycles → rd_data held and req_ready 0 throughout.
  - resp_error on beat 1 of a split load → second beat consumed, then rd_error=1, rd_data 0.
  - Extra beat while in HOLD → stray_resp pulses once, result unchanged.
- Reset: reset_n low while in WAIT_SECOND → all outputs 0, req_ready 1.
  - A fresh aligned request then completes normally with no residue from the aborted one.
